// File: rtl/calc_pkg.sv
// Shared definitions for the binary-to-BCD converter slice.
//   BIN_W_DEF  : default binary input width
//   DIGITS_DEF : default number of BCD digits presented downstream
//   state_t    : converter FSM states
//   ALL_NINES  : all-nines BCD pattern, sliced to 4*DIGITS bits by users
package calc_pkg;

   localparam int BIN_W_DEF  = 16;
   localparam int DIGITS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Wide enough for up to 16 digits; 16'h9999 in the low bits at default.
   localparam logic [63:0] ALL_NINES = {16{4'h9}};

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit correction: adds 3 to a BCD digit
// that is 5 or more, so the following left shift carries correctly.
//   digit    : current scratch digit
//   adjusted : digit corrected ahead of the shift
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   always_comb begin
      adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
   end

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
//   clk     : system clock, rising edge
//   clear_n : asynchronous active-low reset
//   start   : request conversion of bin (accepted only while ready)
//   bin     : unsigned binary value, sampled on the accepting edge
//   ready   : idle and able to accept start
//   done    : one-cycle pulse when bcd/ovf are freshly updated
//   bcd     : packed BCD result, digit 0 in [3:0]
//   ovf     : value exceeded 10^DIGITS-1
// Optional macro BIN2BCD_SATURATE_EN: overflowing results load all nines
// into bcd; otherwise bcd carries the value modulo 10^DIGITS.
module bin2bcd_converter
   import calc_pkg::*;
#(
   parameter int BIN_W  = BIN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   // One extra scratch digit so full-scale inputs convert without loss.
   localparam int SW = 4 * (DIGITS + 1);
   localparam int CW = $clog2(BIN_W + 1);

   state_t              state, state_nxt;
   logic [BIN_W-1:0]    sreg;
   logic [SW-1:0]       scratch;
   logic [SW-1:0]       adj;
   logic [SW-1:0]       scratch_nxt;
   logic                spill;
   logic [CW-1:0]       cnt;
   logic                last;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic                ovf_nxt;

   for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (scratch[4*g +: 4]),
         .adjusted (adj[4*g +: 4])
      );
   end

   // Shift {adjusted scratch, shift register} left by one; the bit leaving
   // the top of the scratch can only be set by an out-of-range value.
   assign {spill, scratch_nxt} = {adj, sreg[BIN_W-1]};
   assign last    = (cnt == CW'(1));
   assign ovf_nxt = spill | (|scratch_nxt[SW-1:4*DIGITS]);

   always_comb begin
      bcd_nxt = scratch_nxt[4*DIGITS-1:0];
`ifdef BIN2BCD_SATURATE_EN
      if (ovf_nxt) begin
         bcd_nxt = ALL_NINES[4*DIGITS-1:0];
      end
`endif
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sreg    <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd     <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sreg    <= bin;
                  scratch <= '0;
                  cnt     <= CW'(BIN_W);
               end
            end
            SHIFT: begin
               scratch <= scratch_nxt;
               sreg    <= {sreg[BIN_W-2:0], 1'b0};
               cnt     <= cnt - CW'(1);
               if (last) begin
                  bcd <= bcd_nxt;
                  ovf <= ovf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter at default parameters.
// Expected results come from decimal arithmetic on the input value.
// Honors BIN2BCD_SATURATE_EN the same way as the design build.
module tb_bin2bcd_converter;

   localparam int BIN_W  = 16;
   localparam int DIGITS = 4;
   localparam int LAT    = BIN_W + 1;   // accepting edge counted as edge 1

   logic        clk;
   logic        clear_n;
   logic        start;
   logic [15:0] bin;
   logic        ready;
   logic        done;
   logic [15:0] bcd;
   logic        ovf;

   int unsigned total;
   int unsigned bad;

   bin2bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .start   (start),
      .bin     (bin),
      .ready   (ready),
      .done    (done),
      .bcd     (bcd),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_bcd(input int unsigned v);
      logic [15:0] b;
      int unsigned r;
`ifdef BIN2BCD_SATURATE_EN
      if (v > 9999) return 16'h9999;
`endif
      b = '0;
      r = v % 10000;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic logic ref_ovf(input int unsigned v);
      return v > 9999;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int unsigned n;
      n = 0;
      while (!ready && n < 50) begin
         step();
         n++;
      end
      check("wait_ready", ready, 1'b1);
   endtask

   // Drive one conversion, scramble bin after acceptance, check latency and result.
   task automatic do_conv(input string tag, input int unsigned v);
      int unsigned lat;
      wait_ready();
      @(negedge clk);
      bin   = 16'(v);
      start = 1'b1;
      step();
      lat   = 1;
      start = 1'b0;
      bin   = 16'($urandom);
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, lat, LAT);
      check({tag, "_bcd"}, bcd, ref_bcd(v));
      check({tag, "_ovf"}, ovf, ref_ovf(v));
      step();
      check({tag, "_done_clr"}, done, 1'b0);
      check({tag, "_ready"}, ready, 1'b1);
      check({tag, "_hold"}, bcd, ref_bcd(v));
   endtask

   initial begin
      int unsigned v1;
      int unsigned lat;
      int unsigned ndone;
      int unsigned cyc;
      int unsigned times[$];

      total   = 0;
      bad     = 0;
      clear_n = 1'b0;
      start   = 1'b0;
      bin     = '0;
      #12;
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_bcd", bcd, 16'h0000);
      check("rst_ovf", ovf, 1'b0);
      @(negedge clk);
      clear_n = 1'b1;

      do_conv("zero", 0);
      do_conv("v1234", 16'h04D2);
      do_conv("v9999", 9999);
      do_conv("v10000", 10000);
      do_conv("v65535", 65535);
      do_conv("v10001", 10001);
      do_conv("v42", 42);
      for (int i = 0; i < 12; i++) begin
         do_conv("rand", $urandom_range(0, 65535));
      end
      for (int i = 0; i < 4; i++) begin
         do_conv("rand_lo", $urandom_range(0, 9999));
      end

      // A second start during a busy conversion is dropped.
      v1 = $urandom_range(0, 65535);
      wait_ready();
      @(negedge clk);
      bin   = 16'(v1);
      start = 1'b1;
      step();
      lat   = 1;
      start = 1'b0;
      ndone = 0;
      while (lat < 45) begin
         if (lat == 5) begin
            start = 1'b1;
            bin   = 16'd7;
         end else begin
            start = 1'b0;
         end
         step();
         lat++;
         if (done) begin
            ndone++;
            check("busy_bcd", bcd, ref_bcd(v1));
         end
      end
      start = 1'b0;
      check("busy_ndone", ndone, 1);
      check("busy_bcd_end", bcd, ref_bcd(v1));

      // Start held high: back-to-back conversions every BIN_W+2 cycles.
      v1 = $urandom_range(0, 65535);
      wait_ready();
      @(negedge clk);
      bin   = 16'(v1);
      start = 1'b1;
      cyc   = 0;
      times.delete();
      while (cyc < 70) begin
         step();
         cyc++;
         if (done) begin
            times.push_back(cyc);
            check("b2b_bcd", bcd, ref_bcd(v1));
         end
      end
      start = 1'b0;
      check("b2b_count", times.size(), 3);
      for (int i = 1; i < times.size(); i++) begin
         check("b2b_space", times[i] - times[i-1], BIN_W + 2);
      end

      // Reset in the middle of SHIFT aborts without a done pulse.
      wait_ready();
      do_conv("pre_rst", 9876);
      @(negedge clk);
      bin   = 16'd500;
      start = 1'b1;
      step();
      lat   = 1;
      start = 1'b0;
      while (lat < 8) begin
         step();
         lat++;
      end
      check("mid_ready", ready, 1'b0);
      #2;
      clear_n = 1'b0;
      #1;
      check("abort_ready", ready, 1'b1);
      check("abort_bcd", bcd, 16'h0000);
      check("abort_ovf", ovf, 1'b0);
      check("abort_done", done, 1'b0);
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) ndone++;
      end
      @(negedge clk);
      clear_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) ndone++;
      end
      check("abort_nodone", ndone, 0);
      do_conv("post_rst42", 42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
